// File: rtl/mem_port_arbiter.sv
// Round-robin arbitrated front end for a single-port byte-writable memory.
// One grant per cycle; responses return in acceptance order after READ_LAT cycles.
module mem_port_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int MEM_DEPTH  = 64,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int BE_WIDTH   = DATA_WIDTH / 8,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_CH-1:0]              i_req_valid,
  output logic [NUM_CH-1:0]              o_req_ready,
  input  logic [NUM_CH-1:0]              i_req_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [NUM_CH*BE_WIDTH-1:0]     i_req_be,
  output logic [NUM_CH-1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]          o_rsp_rdata,
  output logic                           o_rsp_err,
  output logic                           o_busy
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam int HEAD = READ_LAT - 1;

  logic [CH_W-1:0]       r_rr;
  logic [NUM_CH-1:0]     w_grant;
  logic [CH_W-1:0]       w_gnt_id;
  logic [CH_W-1:0]       w_rr_next;
  logic                  w_found;
  logic                  w_accept;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [BE_WIDTH-1:0]   w_sel_be;
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [READ_LAT-1:0]   r_pv;
  logic [READ_LAT-1:0]   r_perr;
  logic [CH_W-1:0]       r_pid   [READ_LAT];
  logic [DATA_WIDTH-1:0] r_pdata [READ_LAT];

  // Search offsets rr, rr+1, ... so the first valid channel found wins.
  always_comb begin
    w_grant     = '0;
    w_gnt_id    = '0;
    w_rr_next   = r_rr;
    w_found     = 1'b0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_found && i_req_valid[c] && (c == (int'(r_rr) + k) % NUM_CH)) begin
          w_found    = 1'b1;
          w_grant[c] = 1'b1;
          w_gnt_id   = CH_W'(c);
          w_rr_next  = CH_W'((c + 1) % NUM_CH);
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_grant[c]) begin
        w_sel_we    = i_req_we[c];
        w_sel_addr  = i_req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = i_req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
        w_sel_be    = i_req_be[c*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  // Grant is suppressed while reset is held so nothing is accepted or written.
  assign o_req_ready = w_grant & {NUM_CH{i_rst_n}};
  assign w_accept    = w_found & i_rst_n;
  assign w_in_range  = ({1'b0, w_sel_addr} < DEPTH_W);
  assign w_rd_data   = (!w_sel_we && w_in_range) ? r_mem[w_sel_addr] : '0;

  // Memory is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge i_clk) begin
    if (w_accept && w_sel_we && w_in_range) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (w_sel_be[b]) r_mem[w_sel_addr][8*b +: 8] <= w_sel_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr   <= '0;
      r_pv   <= '0;
      r_perr <= '0;
      for (int s = 0; s < READ_LAT; s++) begin
        r_pid[s]   <= '0;
        r_pdata[s] <= '0;
      end
    end else begin
      r_pv[0]    <= w_accept;
      r_perr[0]  <= w_accept & ~w_in_range;
      r_pid[0]   <= w_gnt_id;
      r_pdata[0] <= w_accept ? w_rd_data : '0;
      for (int s = 1; s < READ_LAT; s++) begin
        r_pv[s]    <= r_pv[s-1];
        r_perr[s]  <= r_perr[s-1];
        r_pid[s]   <= r_pid[s-1];
        r_pdata[s] <= r_pdata[s-1];
      end
      if (w_accept) r_rr <= w_rr_next;
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_pv[HEAD] && (r_pid[HEAD] == CH_W'(c))) o_rsp_valid[c] = 1'b1;
    end
  end

  assign o_rsp_rdata = r_pv[HEAD] ? r_pdata[HEAD] : '0;
  assign o_rsp_err   = r_pv[HEAD] & r_perr[HEAD];
  assign o_busy      = |r_pv;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three parameterisations, vector table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // A: 2 channels, depth 64, latency 1
  logic        a_rst_n;
  logic [1:0]  a_valid, a_we, a_ready, a_rsp_valid;
  logic [11:0] a_addr;
  logic [63:0] a_wdata;
  logic [7:0]  a_be;
  logic [31:0] a_rdata;
  logic        a_err, a_busy;

  mem_port_arbiter #(.NUM_CH(2), .MEM_DEPTH(64), .DATA_WIDTH(32), .READ_LAT(1)) u_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_req_valid(a_valid), .o_req_ready(a_ready),
    .i_req_we(a_we), .i_req_addr(a_addr), .i_req_wdata(a_wdata), .i_req_be(a_be),
    .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rdata), .o_rsp_err(a_err), .o_busy(a_busy));

  // B: 4 channels, depth 48, latency 3
  logic         b_rst_n;
  logic [3:0]   b_valid, b_we, b_ready, b_rsp_valid;
  logic [23:0]  b_addr;
  logic [127:0] b_wdata;
  logic [15:0]  b_be;
  logic [31:0]  b_rdata;
  logic         b_err, b_busy;

  mem_port_arbiter #(.NUM_CH(4), .MEM_DEPTH(48), .DATA_WIDTH(32), .READ_LAT(3)) u_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_req_valid(b_valid), .o_req_ready(b_ready),
    .i_req_we(b_we), .i_req_addr(b_addr), .i_req_wdata(b_wdata), .i_req_be(b_be),
    .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rdata), .o_rsp_err(b_err), .o_busy(b_busy));

  // C: 2 channels, depth 64, latency 2
  logic        c_rst_n;
  logic [1:0]  c_valid, c_we, c_ready, c_rsp_valid;
  logic [11:0] c_addr;
  logic [63:0] c_wdata;
  logic [7:0]  c_be;
  logic [31:0] c_rdata;
  logic        c_err, c_busy;

  mem_port_arbiter #(.NUM_CH(2), .MEM_DEPTH(64), .DATA_WIDTH(32), .READ_LAT(2)) u_c (
    .i_clk(clk), .i_rst_n(c_rst_n), .i_req_valid(c_valid), .o_req_ready(c_ready),
    .i_req_we(c_we), .i_req_addr(c_addr), .i_req_wdata(c_wdata), .i_req_be(c_be),
    .o_rsp_valid(c_rsp_valid), .o_rsp_rdata(c_rdata), .o_rsp_err(c_err), .o_busy(c_busy));

  typedef struct packed {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [5:0]  addr0;
    logic [5:0]  addr1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [1:0]  exp_ready;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic [3:0]  onehot;
    logic        err;
    logic [31:0] data;
    logic [31:0] due;
  } rsp_t;

  vec_t        vt [12];
  rsp_t        m_q [$];
  logic [31:0] m_mem [48];
  int          m_rr  = 0;
  int          m_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_set(input int c, input logic we, input logic [5:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    b_valid[c]         = 1'b1;
    b_we[c]            = we;
    b_addr[6*c +: 6]   = addr;
    b_wdata[32*c +: 32] = wd;
    b_be[4*c +: 4]     = be;
  endtask

  // One cycle of channel B against the model: grant from the rr search, then
  // responses leave the queue exactly READ_LAT edges after acceptance.
  task automatic b_step(output int g);
    rsp_t        e;
    logic [5:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && b_valid[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    end
    #1;
    chk("b_rand_ready", 64'(b_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      a  = b_addr[6*g +: 6];
      wd = b_wdata[32*g +: 32];
      be = b_be[4*g +: 4];
      e.onehot = 4'(1 << g);
      e.err    = (a >= 6'd48);
      e.data   = 32'd0;
      e.due    = 32'(m_cyc + 3);
      if (!e.err) begin
        if (!b_we[g]) e.data = m_mem[a];
        else for (int i = 0; i < 4; i++) if (be[i]) m_mem[a][8*i +: 8] = wd[8*i +: 8];
      end
      m_q.push_back(e);
      m_rr = (g + 1) % 4;
    end
    tick();
    m_cyc++;
    chk("b_rand_busy", 64'(b_busy), 64'(m_q.size() != 0));
    if (m_q.size() != 0 && m_q[0].due == 32'(m_cyc)) begin
      chk("b_rand_rsp_valid", 64'(b_rsp_valid), 64'(m_q[0].onehot));
      chk("b_rand_rsp_err", 64'(b_err), 64'(m_q[0].err));
      chk("b_rand_rdata", 64'(b_rdata), 64'(m_q[0].data));
      void'(m_q.pop_front());
    end else begin
      chk("b_rand_rsp_idle", 64'(b_rsp_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last_g;

    vt[0]  = '{2'b01, 2'b01, 6'd5,  6'd0,  32'hDEADBEEF, 32'h0,        4'hF, 4'h0, 2'b01, 32'h0};
    vt[1]  = '{2'b01, 2'b00, 6'd5,  6'd0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 32'hDEADBEEF};
    vt[2]  = '{2'b10, 2'b10, 6'd0,  6'd3,  32'h0,        32'h11223344, 4'h0, 4'hF, 2'b10, 32'h0};
    vt[3]  = '{2'b10, 2'b10, 6'd0,  6'd3,  32'h0,        32'hAABBCCDD, 4'h0, 4'h5, 2'b10, 32'h0};
    vt[4]  = '{2'b10, 2'b00, 6'd0,  6'd3,  32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 32'h11BB33DD};
    vt[5]  = '{2'b11, 2'b00, 6'd5,  6'd3,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 32'hDEADBEEF};
    vt[6]  = '{2'b11, 2'b00, 6'd5,  6'd3,  32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 32'h11BB33DD};
    vt[7]  = '{2'b00, 2'b00, 6'd0,  6'd0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 32'h0};
    vt[8]  = '{2'b01, 2'b01, 6'd63, 6'd0,  32'hFFFFFFFF, 32'h0,        4'h0, 4'h0, 2'b01, 32'h0};
    vt[9]  = '{2'b01, 2'b01, 6'd63, 6'd0,  32'h01020304, 32'h0,        4'hF, 4'h0, 2'b01, 32'h0};
    vt[10] = '{2'b01, 2'b01, 6'd63, 6'd0,  32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 32'h0};
    vt[11] = '{2'b10, 2'b00, 6'd0,  6'd63, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 32'h01020304};

    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_valid = 2'b11; a_we = '0; a_addr = {6'd3, 6'd5}; a_wdata = '0; a_be = '0;
    b_valid = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0;
    c_valid = '0; c_we = '0; c_addr = '0; c_wdata = '0; c_be = '0;
    tick();
    tick();
    chk("a_reset_ready", 64'(a_ready), 64'd0);
    chk("a_reset_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("a_reset_rdata", 64'(a_rdata), 64'd0);
    chk("a_reset_err", 64'(a_err), 64'd0);
    chk("a_reset_busy", 64'(a_busy), 64'd0);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      a_valid = vt[i].valid;
      a_we    = vt[i].we;
      a_addr  = {vt[i].addr1, vt[i].addr0};
      a_wdata = {vt[i].wd1, vt[i].wd0};
      a_be    = {vt[i].be1, vt[i].be0};
      #1;
      chk($sformatf("a_vec%0d_ready", i), 64'(a_ready), 64'(vt[i].exp_ready));
      tick();
      chk($sformatf("a_vec%0d_rsp_valid", i), 64'(a_rsp_valid), 64'(vt[i].exp_ready));
      chk($sformatf("a_vec%0d_rdata", i), 64'(a_rdata), 64'(vt[i].exp_rdata));
      chk($sformatf("a_vec%0d_err", i), 64'(a_err), 64'd0);
      chk($sformatf("a_vec%0d_busy", i), 64'(a_busy), 64'(|vt[i].exp_ready));
    end

    // Two channels held valid: grants alternate starting from ch0.
    for (int k = 0; k < 6; k++) begin
      a_valid = 2'b11; a_we = 2'b00; a_addr = {6'd3, 6'd5};
      #1;
      chk($sformatf("a_rr%0d_ready", k), 64'(a_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      tick();
      chk($sformatf("a_rr%0d_rsp_valid", k), 64'(a_rsp_valid), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("a_rr%0d_rdata", k), 64'(a_rdata), (k % 2 == 0) ? 64'hDEADBEEF : 64'h11BB33DD);
    end
    a_valid = '0;

    // C: four writes then four back-to-back reads, latency 2.
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        c_valid = 2'b01;
        c_we    = (j < 4) ? 2'b01 : 2'b00;
        c_addr  = {6'd0, 6'(j % 4)};
        c_wdata = {32'h0, 32'(32'h10 + j)};
        c_be    = 8'h0F;
      end else begin
        c_valid = '0;
      end
      #1;
      chk($sformatf("c_b2b%0d_ready", j), 64'(c_ready), (j < 8) ? 64'd1 : 64'd0);
      tick();
      if (j >= 1 && j <= 8) begin
        chk($sformatf("c_b2b%0d_rsp_valid", j), 64'(c_rsp_valid), 64'd1);
        chk($sformatf("c_b2b%0d_rdata", j), 64'(c_rdata), (j >= 5) ? 64'(32'h10 + j - 5) : 64'd0);
      end else begin
        chk($sformatf("c_b2b%0d_rsp_idle", j), 64'(c_rsp_valid), 64'd0);
      end
    end

    // B: seed addr 7 via ch2 (rr 0 -> 3).
    b_valid = '0;
    b_set(2, 1'b1, 6'd7, 32'hCAFEF00D, 4'hF);
    #1;
    chk("b_seed_ready", 64'(b_ready), 64'h4);
    tick();
    b_valid = '0;
    repeat (3) tick();

    // Out-of-range read of addr 50 via ch0 (rr 3 -> search 3,0).
    b_set(0, 1'b0, 6'd50, 32'h0, 4'h0);
    #1;
    chk("b_oor_ready", 64'(b_ready), 64'h1);
    tick();
    b_valid = '0;
    for (int t = 1; t <= 4; t++) begin
      chk($sformatf("b_oor_t%0d_rsp_valid", t), 64'(b_rsp_valid), (t == 3) ? 64'h1 : 64'h0);
      chk($sformatf("b_oor_t%0d_err", t), 64'(b_err), (t == 3) ? 64'h1 : 64'h0);
      chk($sformatf("b_oor_t%0d_rdata", t), 64'(b_rdata), 64'h0);
      chk($sformatf("b_oor_t%0d_busy", t), 64'(b_busy), (t <= 3) ? 64'h1 : 64'h0);
      tick();
    end

    // Reset one cycle after a read is accepted: the response must vanish.
    b_set(1, 1'b0, 6'd7, 32'h0, 4'h0);
    #1;
    chk("b_rmf_ready", 64'(b_ready), 64'h2);
    tick();
    b_valid = '0;
    tick();
    chk("b_rmf_pre_rsp", 64'(b_rsp_valid), 64'h0);
    b_rst_n = 1'b0;
    for (int c = 0; c < 4; c++) b_set(c, 1'b0, 6'd7, 32'h0, 4'h0);
    #1;
    chk("b_rmf_ready_in_reset", 64'(b_ready), 64'h0);
    chk("b_rmf_rdata_in_reset", 64'(b_rdata), 64'h0);
    chk("b_rmf_err_in_reset", 64'(b_err), 64'h0);
    chk("b_rmf_busy_in_reset", 64'(b_busy), 64'h0);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk($sformatf("b_rmf_hold%0d_rsp_valid", t), 64'(b_rsp_valid), 64'h0);
      chk($sformatf("b_rmf_hold%0d_busy", t), 64'(b_busy), 64'h0);
    end
    b_rst_n = 1'b1;
    #1;
    chk("b_rmf_first_grant", 64'(b_ready), 64'h1);
    tick();
    b_valid = '0;
    chk("b_rmf_post_t1", 64'(b_rsp_valid), 64'h0);
    tick();
    chk("b_rmf_post_t2", 64'(b_rsp_valid), 64'h0);
    tick();
    chk("b_rmf_post_rsp_valid", 64'(b_rsp_valid), 64'h1);
    chk("b_rmf_mem_intact", 64'(b_rdata), 64'hCAFEF00D);
    tick();

    // Four-way round robin from a fresh reset.
    b_rst_n = 1'b0;
    tick();
    b_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) for (int c = 0; c < 4; c++) b_set(c, 1'b0, 6'd7, 32'h0, 4'h0);
      else b_valid = '0;
      #1;
      chk($sformatf("b_rr%0d_ready", k), 64'(b_ready), (k < 8) ? (64'd1 << (k % 4)) : 64'd0);
      tick();
      if (k >= 2) begin
        chk($sformatf("b_rr%0d_rsp_valid", k), 64'(b_rsp_valid), 64'd1 << ((k - 2) % 4));
        chk($sformatf("b_rr%0d_rdata", k), 64'(b_rdata), 64'hCAFEF00D);
      end else begin
        chk($sformatf("b_rr%0d_rsp_idle", k), 64'(b_rsp_valid), 64'd0);
      end
    end

    // Randomized run: preload every word, then mixed traffic with held requests.
    b_rst_n = 1'b0;
    tick();
    b_rst_n = 1'b1;
    b_valid = '0;
    m_rr    = 0;
    m_q.delete();
    last_g  = -1;
    for (int n = 0; n < 48 + 400; n++) begin
      if (n < 48) begin
        b_valid = '0;
        b_set(0, 1'b1, 6'(n), 32'($urandom), 4'hF);
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (!b_valid[c] || last_g == c) begin
            if ($urandom_range(0, 2) != 0)
              b_set(c, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                    32'($urandom), 4'($urandom_range(0, 15)));
            else
              b_valid[c] = 1'b0;
          end
        end
      end
      b_step(last_g);
    end
    b_valid = '0;
    repeat (4) b_step(last_g);
    chk("b_rand_drained", 64'(m_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
